// File: rtl/logmel_stream_ctrl.sv
// logmel_stream_ctrl: steps the log compressor through every mel bin of a
// frame and collects the results into a two-bank frame buffer. Full banks
// are streamed to the CNN over valid/ready. Frames that arrive while no bank
// can take them are dropped and counted.
module logmel_stream_ctrl #(
    parameter int N_MELS    = 40,
    parameter int LOG_OUT_W = 16,
    parameter int OUT_W     = 16,
    parameter int DROP_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      filterbank_done_i,
    output logic [$clog2(N_MELS)-1:0] mel_idx_o,
    output logic                      log_en_o,
    input  logic [LOG_OUT_W-1:0]      log_val_i,
    input  logic                      log_valid_i,
    output logic [OUT_W-1:0]          cnn_data_o,
    output logic                      cnn_valid_o,
    input  logic                      cnn_ready_i,
    output logic                      cnn_last_o,
    output logic                      frame_sent_o,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic [DROP_W-1:0]         drop_cnt_o
);

    localparam int IW    = $clog2(N_MELS);
    localparam int DEPTH = 2 * N_MELS;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [IW-1:0]     LAST_IDX = IW'(N_MELS - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} wr_state_t;

    wr_state_t             r_state, w_state_nxt;
    logic [IW-1:0]         r_mel_idx, r_ret_cnt, r_ld_idx;
    logic                  r_log_en, r_wr_bank, r_rd_bank, r_ld_bank;
    logic [1:0]            r_full, w_full_nxt;
    logic                  r_busy, r_overrun, r_frame_sent;
    logic [DROP_W-1:0]     r_drop_cnt;
    logic [OUT_W-1:0]      r_cnn_data, w_conv;
    logic                  r_cnn_valid, r_cnn_last;
    logic [LOG_OUT_W-1:0]  r_mem [DEPTH];
    logic [LOG_OUT_W-1:0]  w_rd_val;
    logic [AW-1:0]         w_wr_addr, w_rd_addr;
    logic                  w_accept, w_drop, w_ret_ok, w_fill_done;
    logic                  w_xfer, w_last_xfer, w_load;

    // The accept decision looks at the full flag as it stands before the edge,
    // so a bank freed in this very cycle still counts as occupied.
    assign w_accept    = filterbank_done_i && (r_state == ST_IDLE) && !r_full[r_wr_bank];
    assign w_drop      = filterbank_done_i && !w_accept;
    assign w_ret_ok    = log_valid_i && (r_state != ST_IDLE);
    assign w_fill_done = w_ret_ok && (r_state == ST_DRAIN) && (r_ret_cnt == LAST_IDX);

    assign w_xfer      = r_cnn_valid && cnn_ready_i;
    assign w_last_xfer = w_xfer && r_cnn_last;
    assign w_load      = (!r_cnn_valid || w_xfer) && r_full[r_ld_bank];

    assign w_wr_addr = r_wr_bank ? AW'(N_MELS) + AW'(r_ret_cnt) : AW'(r_ret_cnt);
    assign w_rd_addr = r_ld_bank ? AW'(N_MELS) + AW'(r_ld_idx)  : AW'(r_ld_idx);
    assign w_rd_val  = r_mem[w_rd_addr];

    // Narrowing clamps to the signed output range; widening sign-extends.
    generate
        if (OUT_W >= LOG_OUT_W) begin : g_sext
            assign w_conv = OUT_W'($signed(w_rd_val));
        end else begin : g_sat
            logic [LOG_OUT_W-OUT_W:0] w_hi;
            assign w_hi = w_rd_val[LOG_OUT_W-1:OUT_W-1];
            // Saturate when the discarded bits are not a pure sign extension.
            always_comb begin
                if ((&w_hi) || !(|w_hi)) w_conv = w_rd_val[OUT_W-1:0];
                else if (w_rd_val[LOG_OUT_W-1]) w_conv = {1'b1, {(OUT_W-1){1'b0}}};
                else w_conv = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    endgenerate

    // Write FSM next state.
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (r_mel_idx == LAST_IDX) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_fill_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next full flags: fill completion and frame-sent always hit opposite banks.
    always_comb begin
        w_full_nxt = r_full;
        if (w_fill_done) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_last_xfer) w_full_nxt[r_rd_bank] = 1'b0;
    end

    // Write FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Issue sequencer: one mel index per cycle, never stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_log_en  <= 1'b0;
            r_mel_idx <= '0;
        end else begin
            r_log_en <= (w_state_nxt == ST_ISSUE);
            if (w_accept || (r_state == ST_ISSUE && r_mel_idx == LAST_IDX))
                r_mel_idx <= '0;
            else if (r_state == ST_ISSUE)
                r_mel_idx <= r_mel_idx + IW'(1);
        end
    end

    // Return counter, write bank pointer, full flags and busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ret_cnt <= '0;
            r_wr_bank <= 1'b0;
            r_full    <= 2'b00;
            r_busy    <= 1'b0;
        end else begin
            if (w_accept)      r_ret_cnt <= '0;
            else if (w_ret_ok) r_ret_cnt <= r_ret_cnt + IW'(1);
            if (w_fill_done)   r_wr_bank <= ~r_wr_bank;
            r_full <= w_full_nxt;
            r_busy <= (w_state_nxt != ST_IDLE) || (|w_full_nxt);
        end
    end

    // Frame buffer write port.
    // NOTE: the buffer has no reset; its contents are only read after a fill has written them.
    always_ff @(posedge clk) begin
        if (w_ret_ok) r_mem[w_wr_addr] <= log_val_i;
    end

    // Drop accounting: sticky overrun flag and saturating counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (r_drop_cnt != DROP_MAX) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    // Output stage: the load pointer runs ahead of the read bank so the next
    // frame can follow the last element of the current one without a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnn_data   <= '0;
            r_cnn_valid  <= 1'b0;
            r_cnn_last   <= 1'b0;
            r_ld_idx     <= '0;
            r_ld_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_frame_sent <= 1'b0;
        end else begin
            r_frame_sent <= w_last_xfer;
            if (w_last_xfer) r_rd_bank <= ~r_rd_bank;
            if (w_load) begin
                r_cnn_data  <= w_conv;
                r_cnn_valid <= 1'b1;
                r_cnn_last  <= (r_ld_idx == LAST_IDX);
                if (r_ld_idx == LAST_IDX) begin
                    r_ld_idx  <= '0;
                    r_ld_bank <= ~r_ld_bank;
                end else begin
                    r_ld_idx <= r_ld_idx + IW'(1);
                end
            end else if (w_xfer) begin
                r_cnn_valid <= 1'b0;
                r_cnn_last  <= 1'b0;
            end
        end
    end

    assign mel_idx_o    = r_mel_idx;
    assign log_en_o     = r_log_en;
    assign cnn_data_o   = r_cnn_data;
    assign cnn_valid_o  = r_cnn_valid;
    assign cnn_last_o   = r_cnn_last;
    assign frame_sent_o = r_frame_sent;
    assign busy_o       = r_busy;
    assign overrun_o    = r_overrun;
    assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: doc/logmel_stream_ctrl.md
# logmel_stream_ctrl

Frame sequencer and output scheduler for the log-mel front end. On each filterbank completion it steps the log compressor through all mel bins and collects the returned log values into a two-bank (ping-pong) frame buffer. It streams completed frames to the CNN over a valid/ready interface and reports frame completion. Frames arriving while no bank is free are dropped and counted.

## Interface

Parameters:
- N_MELS, 40, mel bins per frame (≥2)
- LOG_OUT_W, 16, log value width, signed
- OUT_W, 16, CNN data width, signed
- DROP_W, 8, drop counter width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- filterbank_done_i  in  1  one-cycle pulse: mel energies for a new frame are valid
- mel_idx_o  out  $clog2(N_MELS)  mel bin index presented to the log compressor
- log_en_o  out  1  issue strobe for mel_idx_o
- log_val_i  in  LOG_OUT_W  log result, returned in issue order
- log_valid_i  in  1  log_val_i valid; any fixed or variable latency ≥1 cycle
- cnn_data_o  out  OUT_W  log-mel feature value
- cnn_valid_o  out  1  cnn_data_o valid
- cnn_ready_i  in  1  CNN backpressure
- cnn_last_o  out  1  marks element N_MELS-1 of a frame
- frame_sent_o  out  1  one-cycle pulse after the last handshake of a frame
- busy_o  out  1  write FSM not IDLE, or any bank full
- overrun_o  out  1  sticky: at least one frame dropped since reset
- drop_cnt_o  out  DROP_W  saturating count of dropped frames

## Operation

- Buffer: 2×N_MELS entries of LOG_OUT_W. Each bank has a full flag.
- wr_bank/rd_bank pointers reset to 0. wr_bank toggles on fill completion. rd_bank toggles on frame sent.
- Write FSM states:
  - IDLE: on filterbank_done_i, if bank[wr_bank] is not full → ISSUE, issue_cnt=0, ret_cnt=0. Otherwise the frame is dropped.
  - ISSUE: log_en_o=1, mel_idx_o=issue_cnt, issue_cnt++. After index N_MELS-1 → DRAIN.
  - DRAIN: wait until ret_cnt==N_MELS.
  - On completion: set bank[wr_bank].full, toggle wr_bank, → IDLE.
- Returns:
  - Each log_valid_i writes log_val_i to bank[wr_bank][ret_cnt], then ret_cnt++. Accepted in both ISSUE and DRAIN.
  - log_valid_i in IDLE, or with ret_cnt==N_MELS, is ignored.
- Drop:
  - Trigger: filterbank_done_i while the FSM is not IDLE, or while in IDLE with bank[wr_bank] full.
  - Effect: overrun_o←1 (sticky); drop_cnt_o increments, saturating at 2^DROP_W-1. No other state changes.
- Read side:
  - When bank[rd_bank] is full, stream rd_idx 0..N_MELS-1.
  - After the handshake at rd_idx N_MELS-1: clear bank[rd_bank].full, toggle rd_bank, pulse frame_sent_o.
- Width conversion:
  - OUT_W ≥ LOG_OUT_W: sign-extend.
  - OUT_W < LOG_OUT_W: saturate to signed OUT_W range.

## Timing

- Reset: every output is 0 and the write FSM is IDLE. Both full flags, all pointers and all counters clear. Buffer contents are don't-care.
- Reset asserted mid-frame aborts the fill and the stream immediately; no frame_sent_o pulse.
- Issue timing: filterbank_done_i accepted at cycle T → log_en_o high cycles T+1..T+N_MELS with mel_idx_o=0..N_MELS-1. log_en_o is never stalled.
- Fill latency: return ret_cnt=N_MELS-1 at cycle R → full flag set at R+1.
- Stream start: from an idle read side, cnn_valid_o rises at R+2 with element 0. All outputs are registered.
- Handshake: a transfer occurs when cnn_valid_o && cnn_ready_i.
  - With valid high and ready low, cnn_data_o and cnn_last_o hold stable.
  - With ready held high, one element per cycle.
  - Back-to-back full banks stream with no bubble between frames.
- frame_sent_o pulses the cycle after the last handshake.
  - cnn_valid_o of the next frame may be high in that same cycle.
- Simultaneous events, all handled in the same cycle:
  - Fill completion and frame sent on opposite banks.
  - filterbank_done_i in the cycle a bank is freed. The accept decision uses the pre-edge full flag, so it is a drop if bank[wr_bank] was still full.
- Saturation: drop_cnt_o holds at max; overrun_o is never cleared except by reset.

## Test plan

- Single frame, log latency 3, cnn_ready_i=1: done pulse at T → log_en_o T+1..T+40 with idx 0..39. Values 100+i are returned. CNN receives 100..139 on 40 consecutive cycles, cnn_last_o on 139, one frame_sent_o pulse.
- Backpressure: cnn_ready_i toggles 1-0-1-0. Data holds stable while stalled, all 40 values arrive in order, frame_sent_o comes only after the 40th handshake.
- Ping-pong: cnn_ready_i=0 and two frames filled (busy_o=1). Raising ready streams frame A then frame B with no bubble between them, giving two frame_sent_o pulses.
- Overrun: both banks full, then a third done pulse arrives. Expect overrun_o=1 and drop_cnt_o=1, with no log_en_o. Also a done pulse during ISSUE → drop_cnt_o=2, and the issue sequence is undisturbed.
- Saturation/width: DROP_W=2 with 5 drops → drop_cnt_o=3. OUT_W=8 with log_val_i=0x7FFF → 0x7F, 0x8000 → 0x80, 0xFFF0 → 0xF0.
- Async reset mid-stream at element 17: outputs drop to 0 immediately. After release, the next frame streams from element 0 of bank 0, with no frame_sent_o for the aborted frame.
